// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulus counter family.
package counter_pkg;

  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Largest value representable in w bits; the natural top count for a width.
  function automatic int unsigned default_max(input int unsigned w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-count generator: one step up or down with wrap or saturate at the boundary.
module counter_step
  import counter_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = default_max(W),
  parameter int unsigned SAT = CNT_WRAP
) (
  input  logic [W-1:0] count_i,
  input  logic         up_i,
  output logic [W-1:0] next_c_o,
  output logic         bnd_c_o
);

  localparam logic [W-1:0] MAX_W  = W'(MAX);
  localparam logic [W-1:0] UP_BND = (SAT == CNT_SAT) ? MAX_W : '0;
  localparam logic [W-1:0] DN_BND = (SAT == CNT_SAT) ? '0 : MAX_W;

  // Boundary values are selected explicitly so a non-power-of-two MAX never relies on overflow.
  always_comb begin
    next_c_o = count_i;
    bnd_c_o  = 1'b0;
    if (up_i) begin
      if (count_i == MAX_W) begin
        bnd_c_o  = 1'b1;
        next_c_o = UP_BND;
      end else begin
        next_c_o = count_i + W'(1);
      end
    end else begin
      if (count_i == '0) begin
        bnd_c_o  = 1'b1;
        next_c_o = DN_BND;
      end else begin
        next_c_o = count_i - W'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with load, wrap/saturate mode,
// terminal-count flag, boundary-event pulse and sticky overflow.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = default_max(W),
  parameter int unsigned SAT = CNT_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         le,
  input  logic [W-1:0] load,
  input  logic         up,
  input  logic         clr_ovf,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         evt,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] count_q, count_d;
  logic         evt_q, evt_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] load_clamp;
  logic [W-1:0] step_next;
  logic         step_bnd;

  // A full-range MAX needs no clamp; comparing against all-ones would be constant.
  if (MAX >= default_max(W)) begin : g_no_clamp
    assign load_clamp = load;
  end else begin : g_clamp
    assign load_clamp = (load > MAX_W) ? MAX_W : load;
  end

  counter_step #(
    .W   (W),
    .MAX (MAX),
    .SAT (SAT)
  ) u_step (
    .count_i  (count_q),
    .up_i     (up),
    .next_c_o (step_next),
    .bnd_c_o  (step_bnd)
  );

  // Priority: load over count; a set of ovf on a boundary beats a same-edge clear.
  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (le) begin
      count_d = load_clamp;
    end else if (ce) begin
      count_d = step_next;
      evt_d   = step_bnd;
      if (step_bnd) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      evt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign evt   = evt_q;
  assign ovf   = ovf_q;
  assign tc    = up ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: four counter configurations against an arithmetic reference model.
module tb_mod_counter;

  logic       clk, reset, ce, le, up, clr_ovf;
  logic [7:0] load8;
  logic [3:0] load4;

  logic [7:0] count0, count2;
  logic [3:0] count1, count3;
  logic       tc0, tc1, tc2, tc3;
  logic       evt0, evt1, evt2, evt3;
  logic       ovf0, ovf1, ovf2, ovf3;

  int checks = 0;
  int errors = 0;

  // Instance 0: 8-bit wrap, 1: decade wrap, 2: 8-bit saturate, 3: decade saturate.
  mod_counter #(.W(8), .MAX(255), .SAT(0)) u_wrap8 (
    .clk(clk), .reset(reset), .ce(ce), .le(le), .load(load8), .up(up), .clr_ovf(clr_ovf),
    .count(count0), .tc(tc0), .evt(evt0), .ovf(ovf0));
  mod_counter #(.W(4), .MAX(9), .SAT(0)) u_dec (
    .clk(clk), .reset(reset), .ce(ce), .le(le), .load(load4), .up(up), .clr_ovf(clr_ovf),
    .count(count1), .tc(tc1), .evt(evt1), .ovf(ovf1));
  mod_counter #(.W(8), .MAX(255), .SAT(1)) u_sat8 (
    .clk(clk), .reset(reset), .ce(ce), .le(le), .load(load8), .up(up), .clr_ovf(clr_ovf),
    .count(count2), .tc(tc2), .evt(evt2), .ovf(ovf2));
  mod_counter #(.W(4), .MAX(9), .SAT(1)) u_decsat (
    .clk(clk), .reset(reset), .ce(ce), .le(le), .load(load4), .up(up), .clr_ovf(clr_ovf),
    .count(count3), .tc(tc3), .evt(evt3), .ovf(ovf3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mx(input int i);
    return (i == 0 || i == 2) ? 255 : 9;
  endfunction

  function automatic int sat(input int i);
    return (i >= 2) ? 1 : 0;
  endfunction

  // Reference model: modulo arithmetic for wrap, min/max clipping for saturate.
  int m_cnt[4] = '{0, 0, 0, 0};
  int m_evt[4] = '{0, 0, 0, 0};
  int m_ovf[4] = '{0, 0, 0, 0};
  int m_ld;

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_cnt[i] = 0;
        m_evt[i] = 0;
        m_ovf[i] = 0;
      end else begin
        m_evt[i] = 0;
        if (le) begin
          m_ld = (i == 0 || i == 2) ? int'(load8) : int'(load4);
          m_cnt[i] = (m_ld > mx(i)) ? mx(i) : m_ld;
        end else if (ce) begin
          if (up) begin
            m_evt[i] = (m_cnt[i] == mx(i)) ? 1 : 0;
            if (sat(i) == 1) m_cnt[i] = (m_cnt[i] + 1 > mx(i)) ? mx(i) : m_cnt[i] + 1;
            else             m_cnt[i] = (m_cnt[i] + 1) % (mx(i) + 1);
          end else begin
            m_evt[i] = (m_cnt[i] == 0) ? 1 : 0;
            if (sat(i) == 1) m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            else             m_cnt[i] = (m_cnt[i] + mx(i)) % (mx(i) + 1);
          end
        end
        if (m_evt[i] == 1)  m_ovf[i] = 1;
        else if (clr_ovf)   m_ovf[i] = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input int c, input logic t, input logic e, input logic o);
    int exp_tc;
    exp_tc = up ? ((m_cnt[i] == mx(i)) ? 1 : 0) : ((m_cnt[i] == 0) ? 1 : 0);
    chk($sformatf("model count[%0d]", i), c, m_cnt[i]);
    chk($sformatf("model tc[%0d]", i), int'(t), exp_tc);
    chk($sformatf("model evt[%0d]", i), int'(e), m_evt[i]);
    chk($sformatf("model ovf[%0d]", i), int'(o), m_ovf[i]);
  endtask

  // Every negative edge: all instances against the model.
  always @(negedge clk) begin
    chk_inst(0, int'(count0), tc0, evt0, ovf0);
    chk_inst(1, int'(count1), tc1, evt1, ovf1);
    chk_inst(2, int'(count2), tc2, evt2, ovf2);
    chk_inst(3, int'(count3), tc3, evt3, ovf3);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int evt_seen;
  int exp_sat[5] = '{254, 255, 255, 255, 255};
  int exp_sev[5] = '{0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1; ce = 1'b0; le = 1'b0; up = 1'b1; clr_ovf = 1'b0;
    load8 = 8'd0; load4 = 4'd0;
    repeat (2) cyc();
    chk("reset count", int'(count0), 0);
    reset = 1'b0;

    // Asynchronous reset from 0x37 mid-count.
    le = 1'b1; load8 = 8'h37; load4 = 4'd3;
    cyc();
    chk("load 0x37", int'(count0), 55);
    le = 1'b0; ce = 1'b1;
    reset = 1'b1;
    #1;
    chk("async reset count", int'(count0), 0);
    chk("async reset evt", int'(evt0), 0);
    chk("async reset ovf", int'(ovf0), 0);
    cyc();
    reset = 1'b0; ce = 1'b0; le = 1'b1; load8 = 8'd13;
    cyc();
    chk("load 13", int'(count0), 13);
    le = 1'b0; ce = 1'b1; up = 1'b1;
    evt_seen = 0;
    repeat (10) begin
      cyc();
      if (evt0) evt_seen++;
    end
    chk("count 23", int'(count0), 23);
    chk("no evt 13..23", evt_seen, 0);

    // 8-bit wrap up.
    ce = 1'b0; le = 1'b1; load8 = 8'd254;
    cyc();
    chk("load 254", int'(count0), 254);
    le = 1'b0; ce = 1'b1;
    cyc();
    chk("wrap 255", int'(count0), 255);
    chk("wrap tc", int'(tc0), 1);
    cyc();
    chk("wrap 0", int'(count0), 0);
    chk("wrap evt", int'(evt0), 1);
    chk("wrap ovf", int'(ovf0), 1);
    cyc();
    chk("wrap 1", int'(count0), 1);
    chk("wrap evt drop", int'(evt0), 0);
    chk("wrap ovf sticky", int'(ovf0), 1);

    // Decade down and clamped load.
    ce = 1'b0; le = 1'b1; load4 = 4'd1; up = 1'b0;
    cyc();
    chk("dec load 1", int'(count1), 1);
    le = 1'b0; ce = 1'b1;
    cyc();
    chk("dec 0", int'(count1), 0);
    chk("dec tc", int'(tc1), 1);
    cyc();
    chk("dec 9", int'(count1), 9);
    chk("dec evt", int'(evt1), 1);
    ce = 1'b0; le = 1'b1; load4 = 4'd15;
    cyc();
    chk("dec clamp", int'(count1), 9);
    chk("dec clamp evt", int'(evt1), 0);

    // 8-bit saturate.
    le = 1'b1; up = 1'b1; load8 = 8'd253;
    cyc();
    chk("sat load 253", int'(count2), 253);
    le = 1'b0; ce = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("sat count step %0d", k), int'(count2), exp_sat[k]);
      chk($sformatf("sat evt step %0d", k), int'(evt2), exp_sev[k]);
    end
    up = 1'b0;
    cyc();
    chk("sat down 254", int'(count2), 254);
    chk("sat down evt", int'(evt2), 0);

    // Simultaneous events.
    le = 1'b1; ce = 1'b1; load8 = 8'd5;
    cyc();
    chk("le over ce", int'(count0), 5);
    le = 1'b0; ce = 1'b0; clr_ovf = 1'b1;
    cyc();
    chk("clr alone", int'(ovf0), 0);
    clr_ovf = 1'b0; le = 1'b1; load8 = 8'd255; up = 1'b1;
    cyc();
    le = 1'b0; ce = 1'b1; clr_ovf = 1'b1;
    cyc();
    chk("set beats clr count", int'(count0), 0);
    chk("set beats clr ovf", int'(ovf0), 1);
    ce = 1'b0;
    cyc();
    chk("clr after set", int'(ovf0), 0);
    clr_ovf = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      ce      = ($urandom_range(0, 3) != 0);
      le      = ($urandom_range(0, 15) == 0);
      clr_ovf = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) up = ~up;
      load8   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 7));
      load4   = 4'($urandom_range(0, 15));
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
